viz_frame_packer: RTL and testbench
===================================

// Module: viz_frame_packer
// PURPOSE
//  Downstream consumer of the final scaled 24-bit audio sample. Decimates samples at the I2S LR rate,
//  buffers them in a FIFO and streams framed, checksummed packets to the UART transmitter byte by byte.
//  Sits between the audio path / lrclk edge detector and uart_tx; drives the visualizer host link.
// PARAMETERS
//  DECIM             4      keep 1 of every DECIM accepted sample_ticks (>=1)
//  FIFO_DEPTH        16     sample FIFO entries, power of 2, >= SAMPLES_PER_FRAME
//  SAMPLES_PER_FRAME 8      samples per packet (N)
//  SYNC_BYTE         8'hA5  frame header byte
// PORTS
//  clk            in   1   system clock (100 MHz domain)
//  reset_n        in   1   synchronous active-low reset
//  enable         in   1   capture enable; 0 = ignore sample_tick
//  sample_tick    in   1   1-cycle pulse, new sample valid on audio_data
//  audio_data     in   24  signed audio sample
//  tx_done        in   1   1-cycle pulse from uart_tx, current byte finished
//  uart_din       out  8   byte to transmit
//  uart_tx_start  out  1   1-cycle pulse launching uart_din
//  overflow_cnt   out  16  samples dropped because FIFO was full, saturating
//  frame_active   out  1   high from SYNC launch until checksum tx_done
// BEHAVIOUR
//  Reset: uart_din=0, uart_tx_start=0, overflow_cnt=0, frame_active=0; FIFO empty, decim_cnt=0,
//   seq=0, FSM=IDLE. Reset mid-frame aborts the frame; no further start pulses until a new frame.
//  Capture: on sample_tick&&enable: if decim_cnt==DECIM-1, keep sample and set decim_cnt=0, else
//   decim_cnt++. A kept sample pushes audio_data[23:8] (truncate, no rounding). When the FIFO is full
//   and no pop occurs that cycle, the sample is dropped and overflow_cnt++ (holds at 16'hFFFF).
//   sample_tick with enable=0 does not advance decim_cnt.
//  Simultaneous push and pop: both take effect, count unchanged; a push while full is accepted
//   when a pop occurs in the same cycle.
//  Frame = SYNC_BYTE, seq, then N samples each as MSB then LSB, then chk. Total 2N+3 bytes (19 by default).
//   chk = XOR of seq and all sample bytes (SYNC excluded). seq increments by 1 after each completed
//   frame, FF->00 wrap.
//  FSM: IDLE -> SYNC -> SEQ -> MSB -> LSB -> (MSB while samples remain) -> CHK -> IDLE.
//   IDLE: at an edge with fifo_count >= N, enter SYNC. On that same edge, register uart_din=SYNC_BYTE,
//    uart_tx_start=1 and frame_active=1.
//   Each byte state waits for tx_done. At the edge where tx_done is seen, advance the state.
//    On that same edge, register the next byte and pulse uart_tx_start (1 cycle).
//   The sample is popped into a holding register on the edge that launches its MSB byte.
//    Underflow cannot occur because count >= N is checked at frame start.
//   CHK: tx_done clears frame_active and returns the FSM to IDLE. A new frame may launch on the next
//    edge if count >= N.
//  uart_din stays stable from its start pulse until the matching tx_done.
//   tx_done in IDLE is ignored. At most one start pulse is issued per tx_done.
//  enable deassert mid-frame: the frame completes and the FIFO keeps draining whole frames.
//   A partial frame is never sent.
//  Latency: condition true at edge e -> uart_tx_start high in cycle e+1. tx_done at edge k ->
//   next uart_tx_start high in cycle k+1.
// TESTING
//  T1 default params, enable=1, 32 ticks, audio_data={16'(i),8'h5A} i=0..31, tx_done 10 cycles after
//     each start -> bytes A5,00,00,03,00,07,...,00,1F,chk=XOR(00,00,03,...,00,1F)=8'h00; overflow_cnt=0.
//  T2 random tx_done delay 1..200 cycles -> exactly one start per tx_done; uart_din stable between them;
//     frame_active spans SYNC start to CHK tx_done.
//  T3 tx_done held 0, 80 ticks (20 kept) -> FSM stuck in SYNC, FIFO holds 16, overflow_cnt=4.
//     Release tx_done -> bytes 3,7,...,63 (MSB 00) across two frames, seq 00 then 01.
//  T4 DECIM=1, 257*8 samples, fast tx_done -> seq runs 00..FF,00; each chk verified.
//  T5 reset_n low for 1 cycle during the 5th byte -> next cycle all outputs at reset values.
//     Next frame begins with A5,00.
//  T6 FIFO full, kept sample in the same cycle as MSB pop -> push accepted, count stays 16, overflow_cnt unchanged.

Source files
------------

// File: rtl/viz_frame_packer_if.sv
// Bundle of the sample-capture inputs and the byte-stream handshake to uart_tx.
//   enable        capture enable
//   sample_tick   1-cycle pulse, audio_data valid
//   audio_data    signed 24-bit sample
//   tx_done       1-cycle pulse, current UART byte finished
//   uart_din      byte to transmit
//   uart_tx_start 1-cycle pulse launching uart_din
// The master modport is the packer side; slave is the environment (audio path + uart_tx).
interface viz_frame_packer_if;
  logic        enable;
  logic        sample_tick;
  logic [23:0] audio_data;
  logic        tx_done;
  logic [7:0]  uart_din;
  logic        uart_tx_start;

  modport master (
    input  enable,
    input  sample_tick,
    input  audio_data,
    input  tx_done,
    output uart_din,
    output uart_tx_start
  );

  modport slave (
    output enable,
    output sample_tick,
    output audio_data,
    output tx_done,
    input  uart_din,
    input  uart_tx_start
  );
endinterface

// File: rtl/viz_frame_packer.sv
// Decimates the scaled audio stream, buffers 16-bit truncated samples in a FIFO and streams
// framed packets (SYNC, seq, N x {MSB, LSB}, XOR checksum) to uart_tx one byte per tx_done.
//   clk          system clock
//   reset_n      synchronous active-low reset
//   bus          sample inputs and UART byte handshake (master side)
//   overflow_cnt kept samples dropped on a full FIFO, saturating
//   frame_active high from SYNC launch until the checksum byte's tx_done
module viz_frame_packer #(
  parameter int unsigned DECIM             = 4,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter int unsigned SAMPLES_PER_FRAME = 8,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic               clk,
  input  logic               reset_n,
  viz_frame_packer_if.master bus,
  output logic [15:0]        overflow_cnt,
  output logic               frame_active
);

  localparam int unsigned DecimW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SmpW   = $clog2(SAMPLES_PER_FRAME + 1);

  localparam logic [DecimW-1:0] DecimLast = DecimW'(DECIM - 1);
  localparam logic [CntW-1:0]   FifoFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]   FrameN    = CntW'(SAMPLES_PER_FRAME);
  localparam logic [SmpW-1:0]   SmpLast   = SmpW'(SAMPLES_PER_FRAME);

  typedef enum logic [2:0] {StIdle, StSync, StSeq, StMsb, StLsb, StChk} state_e;

  state_e            state_q, state_d;
  logic [DecimW-1:0] decim_cnt_q, decim_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [7:0]        din_q, din_d;
  logic              start_q, start_d;
  logic              active_q, active_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        lsb_q, lsb_d;
  logic [SmpW-1:0]   smp_cnt_q, smp_cnt_d;

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [15:0] fifo_rdata;
  logic        tick_ok, keep, fifo_full, push, pop, drop, launch_msb;
  logic        unused_audio_lsb;

  // Truncation drops the low byte of every sample.
  assign unused_audio_lsb = ^bus.audio_data[7:0];

  assign fifo_rdata = mem_q[rd_ptr_q];
  assign fifo_full  = (count_q == FifoFull);

  // Decimation: only enabled ticks advance the phase counter.
  always_comb begin
    tick_ok     = bus.sample_tick && bus.enable;
    keep        = tick_ok && (decim_cnt_q == DecimLast);
    decim_cnt_d = decim_cnt_q;
    if (tick_ok) begin
      decim_cnt_d = keep ? '0 : decim_cnt_q + 1'b1;
    end
  end

  // Frame FSM. Every byte launch registers uart_din and a 1-cycle start pulse on the same edge
  // that advances the state, so uart_din holds until the matching tx_done.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    start_d    = 1'b0;
    active_d   = active_q;
    seq_d      = seq_q;
    chk_d      = chk_q;
    lsb_d      = lsb_q;
    smp_cnt_d  = smp_cnt_q;
    pop        = 1'b0;
    launch_msb = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q >= FrameN) begin
          state_d   = StSync;
          din_d     = SYNC_BYTE;
          start_d   = 1'b1;
          active_d  = 1'b1;
          smp_cnt_d = '0;
        end
      end
      StSync: begin
        if (bus.tx_done) begin
          state_d = StSeq;
          din_d   = seq_q;
          start_d = 1'b1;
          chk_d   = seq_q;
        end
      end
      StSeq: begin
        if (bus.tx_done) begin
          launch_msb = 1'b1;
        end
      end
      StMsb: begin
        if (bus.tx_done) begin
          state_d = StLsb;
          din_d   = lsb_q;
          start_d = 1'b1;
          chk_d   = chk_q ^ lsb_q;
        end
      end
      StLsb: begin
        if (bus.tx_done) begin
          if (smp_cnt_q == SmpLast) begin
            state_d = StChk;
            din_d   = chk_q;
            start_d = 1'b1;
          end else begin
            launch_msb = 1'b1;
          end
        end
      end
      StChk: begin
        if (bus.tx_done) begin
          state_d  = StIdle;
          active_d = 1'b0;
          seq_d    = seq_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The sample leaves the FIFO on the edge that launches its MSB; the LSB is parked until
    // the MSB completes. The frame-start count check guarantees the FIFO is non-empty here.
    if (launch_msb) begin
      state_d   = StMsb;
      pop       = 1'b1;
      din_d     = fifo_rdata[15:8];
      lsb_d     = fifo_rdata[7:0];
      start_d   = 1'b1;
      chk_d     = chk_q ^ fifo_rdata[15:8];
      smp_cnt_d = smp_cnt_q + 1'b1;
    end
  end

  // FIFO bookkeeping. A same-cycle pop frees the slot, so a push while full is still accepted.
  always_comb begin
    push     = keep && (!fifo_full || pop);
    drop     = keep && fifo_full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      decim_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      din_q       <= '0;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      seq_q       <= '0;
      chk_q       <= '0;
      lsb_q       <= '0;
      smp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      din_q       <= din_d;
      start_q     <= start_d;
      active_q    <= active_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      lsb_q       <= lsb_d;
      smp_cnt_q   <= smp_cnt_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.audio_data[23:8];
    end
  end

  assign bus.uart_din      = din_q;
  assign bus.uart_tx_start = start_q;
  assign overflow_cnt      = ovf_q;
  assign frame_active      = active_q;

endmodule

// File: tb/tb_viz_frame_packer.sv
// Randomised scoreboard bench for viz_frame_packer. A frame-level model turns kept samples into
// expected byte sequences; a monitor pops and compares on every uart_tx_start; a responder
// answers each start with tx_done after a programmable delay.
module tb_viz_frame_packer;
  localparam int unsigned N     = 8;
  localparam int unsigned Decim = 4;
  localparam int unsigned Depth = 16;
  localparam logic [7:0]  Sync  = 8'hA5;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] overflow_cnt;
  logic        frame_active;

  viz_frame_packer_if bus ();

  viz_frame_packer #(
    .DECIM            (Decim),
    .FIFO_DEPTH       (Depth),
    .SAMPLES_PER_FRAME(N),
    .SYNC_BYTE        (Sync)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .overflow_cnt(overflow_cnt),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  exp_t        exp_q[$];
  logic [15:0] pending_q[$];
  logic [7:0]  model_seq  = 8'd0;
  int          acc_ticks  = 0;
  int          kept_total = 0;
  int          exp_ovf    = 0;
  bit          hold_phase = 1'b0;
  int          occ        = 0;

  // Responder / monitor control.
  int unsigned dly_lo     = 1;
  int unsigned dly_hi     = 3;
  bit          auto_done  = 1'b1;
  int          force_req  = 0;
  int          rst_epoch  = 0;
  int          starts_seen = 0;
  bit          mon_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic void push_exp(input logic [7:0] d, input bit last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endfunction

  // Whenever N samples are waiting, a whole frame's bytes become expected.
  function automatic void model_emit_frames();
    logic [7:0]  c;
    logic [15:0] s;
    while (pending_q.size() >= N) begin
      c = model_seq;
      push_exp(Sync, 1'b0);
      push_exp(model_seq, 1'b0);
      for (int k = 0; k < N; k++) begin
        s = pending_q.pop_front();
        push_exp(s[15:8], 1'b0);
        push_exp(s[7:0], 1'b0);
        c = c ^ s[15:8] ^ s[7:0];
      end
      push_exp(c, 1'b1);
      model_seq = model_seq + 8'd1;
    end
  endfunction

  // One sample_tick pulse; pop_now tells the model a FIFO pop coincides with this edge.
  task automatic tick(input logic [23:0] data, input bit en, input bit pop_now);
    @(posedge clk); #1;
    bus.enable      = en;
    bus.sample_tick = 1'b1;
    bus.audio_data  = data;
    if (en) begin
      acc_ticks++;
      if (acc_ticks % Decim == 0) begin
        kept_total++;
        if (hold_phase && occ >= Depth && !pop_now) begin
          if (exp_ovf < 65535) exp_ovf++;
        end else begin
          pending_q.push_back(data[23:8]);
          if (hold_phase && !pop_now) occ++;
          model_emit_frames();
        end
      end
    end
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    rst_epoch++;
    exp_q.delete();
    pending_q.delete();
    model_seq  = 8'd0;
    acc_ticks  = 0;
    exp_ovf    = 0;
    occ        = 0;
    hold_phase = 1'b0;
    @(posedge clk); #1;
    check("rst_uart_din", bus.uart_din, 0);
    check("rst_uart_tx_start", bus.uart_tx_start, 0);
    check("rst_overflow_cnt", overflow_cnt, 0);
    check("rst_frame_active", frame_active, 0);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || mon_pending || frame_active) && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("drain_in_time", (c < budget), 1);
    repeat (3) @(posedge clk);
  endtask

  // tx_done responder: one pulse per observed start after dly_lo..dly_hi cycles, or on request.
  initial begin : responder
    int timer;
    int force_ack;
    int my_epoch;
    timer = 0;
    force_ack = 0;
    my_epoch = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      if (my_epoch != rst_epoch) begin
        my_epoch = rst_epoch;
        timer = 0;
      end
      if (force_ack != force_req) begin
        force_ack = force_req;
        bus.tx_done = 1'b1;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) bus.tx_done = 1'b1;
      end else if (auto_done && bus.uart_tx_start) begin
        timer = int'($urandom_range(dly_hi, dly_lo));
      end
    end
  end

  // Monitor: compares each launched byte with the scoreboard and polices the handshake.
  initial begin : monitor
    logic [7:0] latched;
    bit         changed;
    bit         last_byte;
    bit         fa_check;
    int         my_epoch;
    exp_t       e;
    latched = 8'd0;
    changed = 1'b0;
    last_byte = 1'b0;
    fa_check = 1'b0;
    my_epoch = 0;
    forever begin
      @(negedge clk);
      if (my_epoch != rst_epoch) begin
        my_epoch = rst_epoch;
        mon_pending = 1'b0;
        fa_check = 1'b0;
      end
      if (fa_check) begin
        check("frame_active_clear_after_chk", frame_active, 0);
        fa_check = 1'b0;
      end
      if (mon_pending && bus.uart_din !== latched) changed = 1'b1;
      if (bus.tx_done && mon_pending) begin
        check("uart_din_stable", {changed, bus.uart_din}, {1'b0, latched});
        mon_pending = 1'b0;
        if (last_byte) fa_check = 1'b1;
      end
      if (bus.uart_tx_start === 1'b1) begin
        starts_seen++;
        check("single_start_per_done", mon_pending, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: got byte %02h, required no start", bus.uart_din);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", bus.uart_din, e.data);
          check("frame_active_during_byte", frame_active, 1);
          last_byte = e.last;
        end
        latched = bus.uart_din;
        changed = 1'b0;
        mon_pending = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    n_checks++;
    $display("FAIL watchdog: got still running at 90000 cycles, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int c;
    int target;
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.sample_tick = 1'b0;
    bus.audio_data  = 24'd0;
    do_reset();

    // Deterministic ramp, fixed 10-cycle tx_done latency.
    dly_lo = 10;
    dly_hi = 10;
    for (int i = 0; i < 32; i++) tick({16'(i), 8'h5A}, 1'b1, 1'b0);
    wait_drain(2000);
    check("t1_overflow_cnt", overflow_cnt, 0);

    // Random data, random enable gaps, slow and irregular UART.
    do_reset();
    dly_lo = 1;
    dly_hi = 200;
    for (int b = 0; b < 2; b++) begin
      target = kept_total + 16;
      while (kept_total < target) begin
        tick(24'($urandom), ($urandom_range(9, 0) != 0), 1'b0);
      end
      wait_drain(20000);
    end
    check("t2_overflow_cnt", overflow_cnt, 0);

    // UART stalled: FIFO fills, excess samples are dropped.
    do_reset();
    auto_done  = 1'b0;
    hold_phase = 1'b1;
    dly_lo = 1;
    dly_hi = 5;
    base = starts_seen;
    for (int i = 0; i < 80; i++) tick({16'(i), 8'h5A}, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    check("t3_overflow_cnt", overflow_cnt, exp_ovf);
    check("t3_stuck_frame_active", frame_active, 1);
    check("t3_stuck_sync_din", bus.uart_din, Sync);
    check("t3_only_sync_started", starts_seen - base, 1);

    // Finish SYNC, then land a kept sample on the very edge that pops the first MSB.
    @(posedge clk); #2;
    force_req++;
    c = 0;
    while (starts_seen < base + 2 && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("t6_seq_launched", starts_seen - base, 2);
    for (int i = 80; i < 83; i++) tick({16'(i), 8'h5A}, 1'b1, 1'b0);
    @(posedge clk); #2;
    force_req++;
    auto_done = 1'b1;
    tick({16'(83), 8'h5A}, 1'b1, 1'b1);
    hold_phase = 1'b0;
    wait_drain(5000);
    check("t6_overflow_unchanged", overflow_cnt, exp_ovf);
    for (int i = 84; i < 112; i++) tick({16'(i), 8'h5A}, 1'b1, 1'b0);
    wait_drain(5000);

    // 258 frames so the sequence number wraps through FF to 00.
    do_reset();
    dly_lo = 1;
    dly_hi = 3;
    for (int b = 0; b < 129; b++) begin
      for (int i = 0; i < 64; i++) tick(24'($urandom), 1'b1, 1'b0);
      wait_drain(3000);
    end
    check("t4_overflow_cnt", overflow_cnt, 0);

    // Reset in the middle of the fifth byte aborts the frame.
    do_reset();
    dly_lo = 2;
    dly_hi = 6;
    base = starts_seen;
    for (int i = 0; i < 32; i++) tick(24'($urandom), 1'b1, 1'b0);
    c = 0;
    while (starts_seen < base + 5 && c < 2000) begin
      @(negedge clk); #1;
      c++;
    end
    check("t5_fifth_byte_reached", (c < 2000), 1);
    do_reset();
    repeat (20) @(posedge clk);
    for (int i = 0; i < 32; i++) tick(24'($urandom), 1'b1, 1'b0);
    wait_drain(2000);
    check("t5_overflow_cnt", overflow_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
